// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus definitions for the pipeline stall sequencer.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;

  // Per-request stall codes; a deeper request freezes every earlier stage.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000001;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b001111;

  // Bit positions on the stall bus (bit 5 is reserved and always 0).
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;

  // The codes are nested masks, so OR-ing them yields the deepest one.
  function automatic logic [STALL_W-1:0] merge_stall(input logic req_if,
                                                      input logic req_id,
                                                      input logic req_ex,
                                                      input logic req_mem);
    logic [STALL_W-1:0] code;
    code = STALL_NONE;
    if (req_if)  code = code | STALL_IF;
    if (req_id)  code = code | STALL_ID;
    if (req_ex)  code = code | STALL_EX;
    if (req_mem) code = code | STALL_MEM;
    return code;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_inst_hold_buf.sv
// Holds the word returned by the synchronous inst SRAM while IF/ID is frozen,
// so ID sees the word that belonged to the stalled fetch once the stall drops.
module inst_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_en,
  input  logic [31:0] rdata_in,
  output logic [31:0] inst_out
);

  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_buf_q, hold_buf_d;

  // Capture on the first frozen cycle, keep through the stall, release after.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_buf_d   = hold_buf_q;
    if (hold_en) begin
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_buf_d   = rdata_in;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  // Holding register with synchronous reset; a held word is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_buf_q   <= 32'h0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_buf_q   <= hold_buf_d;
    end
  end

  // The held word stays visible for one cycle after release, then SRAM data.
  always_comb begin
    inst_out = rdata_in;
    if (!rst && hold_valid_q) inst_out = hold_buf_q;
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/bubble sequencer: merges stage requests into the stall bus,
// holds the fetched word across IF/ID freezes, counts stalled cycles and
// raises a sticky watchdog when the PC stays frozen too long.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int WDOG_CYCLES = 1024,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_for_if,
  input  logic               stallreq_for_id,
  input  logic               stallreq_for_ex,
  input  logic               stallreq_for_mem,
  input  logic [31:0]        inst_sram_rdata,
  output logic [STALL_W-1:0] stall,
  output logic [31:0]        inst_to_id,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               wdog_timeout
);

  localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_TRIP = WDOG_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_timeout_q, wdog_timeout_d;

  // Zero-latency request merge; the bus is idle while reset is asserted.
  always_comb begin
    stall = STALL_NONE;
    if (!rst) begin
      stall = merge_stall(stallreq_for_if, stallreq_for_id,
                          stallreq_for_ex, stallreq_for_mem);
    end
  end

  inst_hold_buf u_hold (
    .clk      (clk),
    .rst      (rst),
    .hold_en  (stall[STALL_IFID]),
    .rdata_in (inst_sram_rdata),
    .inst_out (inst_to_id)
  );

  // Counter and watchdog next state: both advance only while the PC is frozen.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    wdog_cnt_d     = '0;
    wdog_timeout_d = wdog_timeout_q;
    if (stall[STALL_PC]) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
      wdog_cnt_d  = (wdog_cnt_q >= WDOG_MAX) ? WDOG_MAX : wdog_cnt_q + 1'b1;
      if (wdog_cnt_q >= WDOG_TRIP) wdog_timeout_d = 1'b1;
    end
  end

  // Performance counter and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q    <= '0;
      wdog_cnt_q     <= '0;
      wdog_timeout_q <= 1'b0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      wdog_cnt_q     <= wdog_cnt_d;
      wdog_timeout_q <= wdog_timeout_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign wdog_timeout = wdog_timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int WDOG  = 8;
  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     = 1'b1;
  logic        req_if  = 1'b1;
  logic        req_id  = 1'b1;
  logic        req_ex  = 1'b1;
  logic        req_mem = 1'b1;
  logic [31:0] rdata   = 32'h0;

  logic [5:0]       stall;
  logic [31:0]      inst_to_id;
  logic [CNT_W-1:0] stall_cnt;
  logic             wdog_timeout;

  pipe_stall_ctrl #(.WDOG_CYCLES(WDOG), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_for_if  (req_if),
    .stallreq_for_id  (req_id),
    .stallreq_for_ex  (req_ex),
    .stallreq_for_mem (req_mem),
    .inst_sram_rdata  (rdata),
    .stall            (stall),
    .inst_to_id       (inst_to_id),
    .stall_cnt        (stall_cnt),
    .wdog_timeout     (wdog_timeout)
  );

  // ---------------- behavioural model ----------------
  // Deepest request wins; each deeper stage freezes all earlier ones.
  function automatic logic [5:0] exp_stall(input logic r, input logic i,
                                           input logic d, input logic e,
                                           input logic m);
    if (r) return 6'b000000;
    if (m) return 6'b001111;
    if (e) return 6'b000111;
    if (d) return 6'b000011;
    if (i) return 6'b000001;
    return 6'b000000;
  endfunction

  logic             m_held = 1'b0;
  logic [31:0]      m_word = 32'h0;
  logic [CNT_W-1:0] m_cnt  = '0;
  int               m_run  = 0;   // consecutive frozen-PC cycles so far
  logic             m_trip = 1'b0;

  always @(posedge clk) begin
    logic [5:0] s;
    s = exp_stall(rst, req_if, req_id, req_ex, req_mem);
    if (rst) begin
      m_held <= 1'b0;
      m_word <= 32'h0;
      m_cnt  <= '0;
      m_run  <= 0;
      m_trip <= 1'b0;
    end else begin
      if (!s[1])       m_held <= 1'b0;
      else if (!m_held) begin
        m_held <= 1'b1;
        m_word <= rdata;
      end
      if (s[0]) begin
        m_cnt <= m_cnt + 1;
        if (m_run + 1 >= WDOG) m_trip <= 1'b1;
        m_run <= (m_run + 1 > WDOG) ? WDOG : m_run + 1;
      end else begin
        m_run <= 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then compare all outputs to the model.
  task automatic step(input logic r, input logic [3:0] req, input logic [31:0] d);
    @(negedge clk);
    rst = r;
    {req_mem, req_ex, req_id, req_if} = req;
    rdata = d;
    #1;
    chk("model_stall", {58'h0, stall},
        {58'h0, exp_stall(rst, req_if, req_id, req_ex, req_mem)});
    chk("model_inst", {32'h0, inst_to_id},
        {32'h0, (!rst && m_held) ? m_word : rdata});
    chk("model_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("model_wdog", {63'h0, wdog_timeout}, {63'h0, m_trip});
  endtask

  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_IF   = 4'b0001;
  localparam logic [3:0] R_ID   = 4'b0010;
  localparam logic [3:0] R_EX   = 4'b0100;
  localparam logic [3:0] R_MEM  = 4'b1000;

  // ---------------- stimulus ----------------
  initial begin
    // Reset with every request asserted.
    step(1'b1, 4'b1111, 32'h0);
    step(1'b1, 4'b1111, 32'h0);
    chk("rst_stall", {58'h0, stall}, 64'h0);
    chk("rst_cnt", 64'(stall_cnt), 64'h0);
    chk("rst_wdog", {63'h0, wdog_timeout}, 64'h0);
    step(1'b0, 4'b1111, 32'h0);
    chk("post_rst_stall", {58'h0, stall}, 64'h0f);

    // Load-use bubble.
    step(1'b1, R_NONE, 32'h0);
    step(1'b0, R_ID, 32'h8C220004);
    chk("lu_stall", {58'h0, stall}, 64'h03);
    step(1'b0, R_NONE, 32'h00431020);
    chk("lu_held", {32'h0, inst_to_id}, 64'h8C220004);
    step(1'b0, R_NONE, 32'h00431020);
    chk("lu_next", {32'h0, inst_to_id}, 64'h00431020);
    chk("lu_cnt", 64'(stall_cnt), 64'd1);

    // Priority of simultaneous requests.
    step(1'b1, R_NONE, 32'h0);
    step(1'b0, R_ID | R_EX | R_IF, 32'h0);
    chk("pri_all", {58'h0, stall}, 64'h07);
    step(1'b0, R_ID | R_IF, 32'h0);
    chk("pri_id_if", {58'h0, stall}, 64'h03);
    step(1'b0, R_IF, 32'h0);
    chk("pri_if", {58'h0, stall}, 64'h01);
    step(1'b0, R_NONE, 32'h0);
    chk("pri_none", {58'h0, stall}, 64'h00);
    chk("pri_cnt", 64'(stall_cnt), 64'd3);

    // Hold stability across a five-cycle EX stall.
    step(1'b1, R_NONE, 32'h0);
    for (int k = 1; k <= 6; k++) exp_q.push_back(32'h1);
    exp_q.push_back(32'h7);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, (k <= 5) ? R_EX : R_NONE, 32'(k));
      chk("hold_inst", {32'h0, inst_to_id}, {32'h0, exp_q.pop_front()});
    end

    // Watchdog: seven-cycle burst must not trip, eight-cycle burst must.
    step(1'b1, R_NONE, 32'h0);
    for (int k = 0; k < 7; k++) step(1'b0, R_MEM, 32'h0);
    step(1'b0, R_NONE, 32'h0);
    chk("wd_short", {63'h0, wdog_timeout}, 64'h0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, R_MEM, 32'h0);
      chk("wd_pre", {63'h0, wdog_timeout}, 64'h0);
    end
    step(1'b0, R_NONE, 32'h0);
    chk("wd_trip", {63'h0, wdog_timeout}, 64'h1);
    step(1'b0, R_NONE, 32'h0);
    chk("wd_sticky", {63'h0, wdog_timeout}, 64'h1);
    chk("wd_cnt", 64'(stall_cnt), 64'd15);

    // Reset in the middle of an EX stall with a held word.
    step(1'b1, R_NONE, 32'h0);
    step(1'b0, R_EX, 32'hAAAA0001);
    step(1'b0, R_EX, 32'hAAAA0002);
    chk("mid_held", {32'h0, inst_to_id}, 64'hAAAA0001);
    step(1'b1, R_EX, 32'hAAAA0003);
    chk("mid_rst_inst", {32'h0, inst_to_id}, 64'hAAAA0003);
    step(1'b0, R_NONE, 32'hBBBB0004);
    chk("mid_inst", {32'h0, inst_to_id}, 64'hBBBB0004);
    chk("mid_cnt", 64'(stall_cnt), 64'd0);
    chk("mid_wdog", {63'h0, wdog_timeout}, 64'h0);

    // Randomized traffic alternating sparse and dense request phases.
    for (int k = 0; k < 3000; k++) begin
      logic       dense;
      logic [3:0] req;
      dense = ((k / 100) % 2) == 1;
      for (int b = 0; b < 4; b++)
        req[b] = dense ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 299) == 0, req, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall and bubble sequencer for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB); it supersedes the combinational CTRL.
- Merges per-stage stall requests into the 6-bit stall bus.
- Holds the instruction returned by synchronous inst SRAM while IF/ID is frozen, so ID sees the correct word when the stall releases.
- Keeps a stall-cycle performance counter and a sticky hang watchdog.

Parameters:
WDOG_CYCLES, 1024, consecutive stalled cycles that trip the watchdog (2..2^16-1).
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
stallreq_for_if  in  1  fetch not ready (SRAM wait)
stallreq_for_id  in  1  load-use hazard detected in ID
stallreq_for_ex  in  1  multi-cycle EX op (mul/div) busy
stallreq_for_mem  in  1  data SRAM not ready
inst_sram_rdata  in  32  raw instruction word from inst SRAM
stall  out  6  stall bus; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0)
inst_to_id  out  32  instruction word presented to ID decode
stall_cnt  out  CNT_W  cycles with stall[0]=1 since reset
wdog_timeout  out  1  sticky hang indication

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named rst. Every register updates only on the rising edge of clk.
- Reset values: hold_valid=0, hold_buf=0, stall_cnt=0, wdog_cnt=0, wdog_timeout=0.
- stall is combinational from the requests, with zero latency. It is forced to 0 while rst=1.
- Stall bus semantics:
  - stall[i]=1: pipeline register i keeps its value.
  - stall[i]=1 and stall[i+1]=0: register i+1 loads a bubble (all-zero bus, no write enables).
- Request encoding: the deepest active request wins; the result is the OR of per-request codes.
  - mem: 6'b001111
  - ex: 6'b000111
  - id: 6'b000011 (ID/EX gets bubble)
  - if: 6'b000001 (IF/ID gets bubble)
  - none: 6'b000000
- Simultaneous requests use the deepest code, e.g. id+ex gives 000111.
- Instruction hold buffer:
  - Capture: if stall[1]=1 and hold_valid=0, then at the edge hold_buf<=inst_sram_rdata and hold_valid<=1.
  - While hold_valid=1, hold_buf is not overwritten, even across stall changes between non-zero codes.
  - Release: if stall[1]=0, then at the edge hold_valid<=0.
  - inst_to_id = hold_valid ? hold_buf : inst_sram_rdata, combinational. In the first cycle after the stall drops, ID therefore still sees hold_buf.
  - During rst, inst_to_id = inst_sram_rdata.
- stall_cnt increments by 1 each cycle stall[0]=1 and wraps modulo 2^CNT_W.
- Watchdog:
  - wdog_cnt increments each cycle stall[0]=1, saturating at WDOG_CYCLES. Any cycle with stall[0]=0 clears it to 0.
  - When wdog_cnt reaches WDOG_CYCLES-1 with stall[0] still 1, wdog_timeout<=1 at that edge. It stays 1 until rst.
  - wdog_timeout never alters stall.
- Reset mid-stall: on the next edge all state returns to reset values. The held instruction is discarded.

Decomposition:
- lib/defines.vh holds:
  - `StallBus (6)
  - stall codes STALL_NONE/IF/ID/EX/MEM
  - bit indices STALL_PC, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB
- One sub-module, inst_hold_buf: the capture/release register plus the output mux, with ports clk, rst, hold_en=stall[1], rdata_in, inst_out.
- Request merge, counter and watchdog stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles with all requests=1 -> stall=000000, stall_cnt=0, wdog_timeout=0; after rst=0, stall=001111.
- Load-use: stallreq_for_id=1 for 1 cycle, rdata=0x8C220004 that cycle, then rdata=0x00431020 -> stall=000011 for 1 cycle; the next cycle inst_to_id=0x8C220004 and hold_valid=1; the cycle after, inst_to_id=0x00431020 and stall_cnt=1.
- Priority: id=1, ex=1, if=1 together -> stall=000111. Drop ex -> 000011. Drop id -> 000001. Drop if -> 000000, and stall_cnt=3.
- Hold stability: stallreq_for_ex=1 for 5 cycles with rdata changing 0x1..0x5 -> hold_buf=0x1 throughout and inst_to_id=0x1 until one cycle after release.
- Watchdog (WDOG_CYCLES=8): stallreq_for_mem=1 for 7 cycles, release, then 8 cycles -> no trip on the first burst; wdog_timeout=1 after the 8th cycle of the second burst and it stays 1 after release; stall_cnt=15.
- Reset mid-stall: ex stall active, hold_valid=1, assert rst one cycle -> hold_valid=0, inst_to_id follows rdata, stall_cnt=0.
